alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : sequential ALU, single-cycle logic/add/sub, shift-add multiply
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t               state_q;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;

  logic [WIDTH:0]       alu_d;
  logic [2*WIDTH-1:0]   acc_d;

  // Bit WIDTH of alu_d carries the add carry-out or the subtract borrow.
  always_comb begin
    alu_d = '0;
    case (op_q)
      3'b000:  alu_d = {1'b0, x_q & y_q};
      3'b001:  alu_d = {1'b0, x_q | y_q};
      3'b010:  alu_d = {1'b0, x_q ^ y_q};
      3'b011:  alu_d = {1'b0, ~(x_q & y_q)};
      3'b100:  alu_d = {1'b0, x_q} + {1'b0, y_q};
      3'b101:  alu_d = {1'b0, x_q} - {1'b0, y_q};
      3'b111:  alu_d = {1'b0, ~(x_q | y_q)};
      default: alu_d = '0;
    endcase
  end

  // y_q doubles as the multiplier shift register while in MUL.
  always_comb begin
    acc_d = acc_q + (y_q[0] ? mcand_q : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            x_q     <= x;
            y_q     <= y;
            mcand_q <= {{WIDTH{1'b0}}, x};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= (op == 3'b110) ? MUL : EXEC;
          end
        end
        EXEC: begin
          result  <= alu_d[WIDTH-1:0];
          carry   <= alu_d[WIDTH];
          zero    <= (alu_d[WIDTH-1:0] == '0);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          y_q     <= y_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result  <= acc_d[WIDTH-1:0];
            carry   <= |acc_d[2*WIDTH-1:WIDTH];
            zero    <= (acc_d[WIDTH-1:0] == '0);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
